// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, one result consumer and the arbiter.
// The master side drives requests and rsp_ready; the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_ctrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_ctrl;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_zero;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_out, rsp_zero, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_out, rsp_zero, rsp_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// Each operation runs IDLE (grant/capture) -> EXEC (compute) -> RESP (hold until taken).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             ptr_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       ctrl_r;
  logic             id_r;
  logic [WIDTH-1:0] out_r;
  logic             zero_r;
  logic             ready0_s;
  logic             ready1_s;
  logic [WIDTH-1:0] alu_s;

  // Shift amount is always b[4:0]; sra fills with the operand sign bit.
  function automatic logic [WIDTH-1:0] alu_f(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [4:0]       sh;
    logic [WIDTH-1:0] r;
    sh = b[4:0];
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a << sh;
      3'b101:  r = a >> sh;
      3'b110:  r = $unsigned($signed(a) >>> sh);
      3'b111:  r = a ^ b;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  assign alu_s = alu_f(ctrl_r, a_r, b_r);

  // Next-state and grant decode; ready is suppressed while reset is asserted.
  always_comb begin
    state_s  = state_r;
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rst_n) begin
          state_s = IDLE;
        end else if (bus.req0_valid && (!bus.req1_valid || !ptr_r)) begin
          ready0_s = 1'b1;
          state_s  = EXEC;
        end else if (bus.req1_valid) begin
          ready1_s = 1'b1;
          state_s  = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand capture, result register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 1'b0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      ctrl_r  <= 3'b000;
      id_r    <= 1'b0;
      out_r   <= {WIDTH{1'b0}};
      zero_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (ready0_s || ready1_s) begin
        a_r    <= ready1_s ? bus.req1_a    : bus.req0_a;
        b_r    <= ready1_s ? bus.req1_b    : bus.req0_b;
        ctrl_r <= ready1_s ? bus.req1_ctrl : bus.req0_ctrl;
        id_r   <= ready1_s;
      end
      if (state_r == EXEC) begin
        out_r  <= alu_s;
        zero_r <= (alu_s == {WIDTH{1'b0}});
      end
      // Hand priority to the requester that was not just served.
      if ((state_r == RESP) && bus.rsp_ready) begin
        ptr_r <= ~id_r;
      end
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.rsp_valid  = (state_r == RESP);
  assign bus.rsp_out    = out_r;
  assign bus.rsp_zero   = zero_r;
  assign bus.rsp_id     = id_r;

endmodule
